// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues reads to synchronous program
// memory and buffers returned {pc, word} pairs in a small prefetch FIFO for the core.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [18:0]       mem_rdata,
   output logic [18:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready
);

   localparam int unsigned WORD_W = 19;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned CRD_W  = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [WORD_W-1:0] word_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];

   logic [CRD_W-1:0]  credit_used;
   logic              push;
   logic              pop;

   // Credit uses registered occupancy only, so a same-cycle pop never funds an issue.
   always_comb begin
      credit_used = CRD_W'(count) + CRD_W'(inflight);
      mem_req     = !reset && !redirect && (credit_used < CRD_W'(DEPTH));
      push        = inflight && !redirect;
      pop         = instr_valid && instr_ready;
   end

   assign mem_addr    = fetch_pc;
   assign instr_valid = (count != '0);
   assign instr       = word_mem[rd_ptr];
   assign instr_pc    = pc_mem[rd_ptr];

   // Control state; redirect flushes everything, including a response arriving now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_addr;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= mem_req;
         if (mem_req) begin
            fetch_pc    <= fetch_pc + ADDR_W'(1);
            inflight_pc <= fetch_pc;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            word_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (push) begin
         word_mem[wr_ptr] <= mem_rdata;
         pc_mem[wr_ptr]   <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle table after reset, an accepted-instruction
// scoreboard, and hand-written reset/backpressure/random-ready sequences.
module tb_instr_fetch_unit;
   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned NROWS  = 27;

   logic              clk = 1'b0;
   logic              reset;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [18:0]       mem_rdata;
   logic [18:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;

   logic [4:0] salt;
   int         checks   = 0;
   int         errors   = 0;
   int         accepted = 0;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [18:0]       word;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic              rd;
      logic [ADDR_W-1:0] ra;
      logic              rdy;
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic              v;
      logic [ADDR_W-1:0] pc;
   } vec_t;
   vec_t tbl[NROWS];

   instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   // Synchronous program memory: word = {salt, addr}; garbage when not requested.
   always @(posedge clk) mem_rdata <= mem_req ? {salt, mem_addr} : 19'h7FFFF;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic vec_t mk(input logic rd, input logic [ADDR_W-1:0] ra, input logic rdy,
                               input logic req, input logic [ADDR_W-1:0] addr,
                               input logic v, input logic [ADDR_W-1:0] pc);
      vec_t r;
      r = '{rd, ra, rdy, req, addr, v, pc};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, want);
      end
   endtask

   task automatic expect_stream(input logic [ADDR_W-1:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = ADDR_W'(start + ADDR_W'(i));
         e.word = {salt, e.pc};
         exp_q.push_back(e);
      end
   endtask

   // Let combinational outputs settle, score any handshake taken at the next edge.
   task automatic settle_monitor();
      exp_t e;
      #1;
      if (!reset && instr_valid && instr_ready) begin
         accepted++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got pc %h required no handshake", instr_pc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(instr_pc), 32'(e.pc));
            chk("sb_instr", 32'(instr), 32'(e.word));
         end
      end
   endtask

   task automatic cycle();
      settle_monitor();
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = mk(0, 14'h0,    1, 1, 14'h0,    0, 14'h0);
      tbl[1]  = mk(0, 14'h0,    1, 1, 14'h1,    0, 14'h0);
      tbl[2]  = mk(0, 14'h0,    1, 1, 14'h2,    1, 14'h0);
      tbl[3]  = mk(0, 14'h0,    1, 1, 14'h3,    1, 14'h1);
      tbl[4]  = mk(0, 14'h0,    1, 1, 14'h4,    1, 14'h2);
      tbl[5]  = mk(0, 14'h0,    1, 1, 14'h5,    1, 14'h3);
      tbl[6]  = mk(0, 14'h0,    0, 1, 14'h6,    1, 14'h4);
      tbl[7]  = mk(0, 14'h0,    0, 1, 14'h7,    1, 14'h4);
      tbl[8]  = mk(0, 14'h0,    0, 0, 14'h8,    1, 14'h4);
      tbl[9]  = mk(0, 14'h0,    0, 0, 14'h8,    1, 14'h4);
      tbl[10] = mk(0, 14'h0,    0, 0, 14'h8,    1, 14'h4);
      tbl[11] = mk(0, 14'h0,    1, 0, 14'h8,    1, 14'h4);
      tbl[12] = mk(0, 14'h0,    1, 1, 14'h8,    1, 14'h5);
      tbl[13] = mk(0, 14'h0,    1, 1, 14'h9,    1, 14'h6);
      tbl[14] = mk(0, 14'h0,    1, 1, 14'hA,    1, 14'h7);
      tbl[15] = mk(1, 14'h0100, 0, 0, 14'hB,    1, 14'h8);
      tbl[16] = mk(0, 14'h0,    1, 1, 14'h0100, 0, 14'h0);
      tbl[17] = mk(0, 14'h0,    1, 1, 14'h0101, 0, 14'h0);
      tbl[18] = mk(0, 14'h0,    1, 1, 14'h0102, 1, 14'h0100);
      tbl[19] = mk(0, 14'h0,    1, 1, 14'h0103, 1, 14'h0101);
      tbl[20] = mk(1, 14'h3FFE, 1, 0, 14'h0104, 1, 14'h0102);
      tbl[21] = mk(0, 14'h0,    1, 1, 14'h3FFE, 0, 14'h0);
      tbl[22] = mk(0, 14'h0,    1, 1, 14'h3FFF, 0, 14'h0);
      tbl[23] = mk(0, 14'h0,    1, 1, 14'h0000, 1, 14'h3FFE);
      tbl[24] = mk(0, 14'h0,    1, 1, 14'h0001, 1, 14'h3FFF);
      tbl[25] = mk(0, 14'h0,    1, 1, 14'h0002, 1, 14'h0000);
      tbl[26] = mk(0, 14'h0,    1, 1, 14'h0003, 1, 14'h0001);

      reset = 1'b1; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b1; salt = 5'h00;
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req",   32'(mem_req),     32'd0);
      chk("rst_instr", 32'(instr),       32'd0);
      chk("rst_pc",    32'(instr_pc),    32'd0);
      @(negedge clk);

      // Fill, backpressure, redirect with in-flight read, redirect on handshake, PC wrap.
      expect_stream(14'h0, 8);
      expect_stream(14'h0100, 3);
      expect_stream(14'h3FFE, 4);
      reset = 1'b0;
      for (int i = 0; i < int'(NROWS); i++) begin
         redirect      = tbl[i].rd;
         redirect_addr = tbl[i].ra;
         instr_ready   = tbl[i].rdy;
         settle_monitor();
         chk($sformatf("row%0d_req", i),   32'(mem_req),     32'(tbl[i].req));
         chk($sformatf("row%0d_addr", i),  32'(mem_addr),    32'(tbl[i].addr));
         chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("row%0d_pc", i),    32'(instr_pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d_instr", i), 32'(instr),    32'({salt, tbl[i].pc}));
         end
         @(negedge clk);
      end
      redirect = 1'b0;
      chk("table_drain", 32'(exp_q.size()), 32'd0);

      // Fill the FIFO under backpressure, then reset mid-stream.
      instr_ready = 1'b0;
      repeat (8) cycle();
      #1;
      chk("full_valid", 32'(instr_valid), 32'd1);
      chk("full_req",   32'(mem_req),     32'd0);
      chk("full_pc",    32'(instr_pc),    32'h2);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_req",   32'(mem_req),     32'd0);
      chk("mid_rst_addr",  32'(mem_addr),    32'd0);
      chk("mid_rst_instr", 32'(instr),       32'd0);
      chk("mid_rst_pc",    32'(instr_pc),    32'd0);
      @(negedge clk);
      @(negedge clk);
      salt        = 5'h1B;
      instr_ready = 1'b1;
      expect_stream(14'h0, 12);
      reset = 1'b0;
      for (int n = 0; n < 60 && exp_q.size() != 0; n++) cycle();
      chk("restart_drain", 32'(exp_q.size()), 32'd0);

      // Random backpressure after a redirect; order and content checked by the scoreboard.
      instr_ready   = 1'b0;
      redirect      = 1'b1;
      redirect_addr = 14'h2000;
      cycle();
      redirect = 1'b0;
      expect_stream(14'h2000, 200);
      accepted = 0;
      for (int n = 0; n < 80; n++) begin
         instr_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("rand_progress", 32'(accepted > 20), 32'd1);
      exp_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the 19-bit core: owns the fetch program counter, issues reads to a synchronous program memory and buffers returned 19-bit instruction words in a small prefetch FIFO. Instructions go to the core over a valid/ready handshake. Jump and taken-branch redirects from the core flush the FIFO and squash any in-flight read. Sits between program memory and the core's `instruction` input.

## Interface
- `ADDR_W`, 14, instruction address width; matches the 14-bit jump/branch target field.
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `redirect`  in  1  core requests fetch from a new address (jump or taken branch).
- `redirect_addr`  in  ADDR_W  new fetch address; valid when `redirect`=1.
- `mem_req`  out  1  program memory read request this cycle.
- `mem_addr`  out  ADDR_W  read address; equals `fetch_pc`.
- `mem_rdata`  in  19  read data; valid exactly one cycle after `mem_req`.
- `instr`  out  19  instruction word at FIFO head.
- `instr_pc`  out  ADDR_W  address of `instr`.
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  core accepts `instr` this cycle.

## Operation
- State: `fetch_pc`, FIFO storage of {pc, word} × DEPTH, rd/wr pointers, `count` (0..DEPTH), `inflight` (0/1), `inflight_pc`.
- Issue: `mem_req` = !`redirect` && (`count` + `inflight`) < DEPTH. The credit check uses registered values only; a same-cycle pop gives no extra credit.
- On issue: `fetch_pc` ← `fetch_pc`+1, modulo 2^ADDR_W (0x3FFF → 0x0000). Set `inflight`=1 and `inflight_pc`=`fetch_pc`.
- Return: in the cycle after issue, if no redirect is asserted in that cycle, push {`inflight_pc`, `mem_rdata`} into the FIFO. `inflight` clears unless a new issue occurs.
- Pop: a handshake (`instr_valid` && `instr_ready`) advances the read pointer. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority):
  - `fetch_pc` ← `redirect_addr`.
  - FIFO cleared (`count`=0, pointers reset).
  - `inflight` cleared; a response arriving in the redirect cycle is discarded.
  - No `mem_req` in the redirect cycle.
- Redirect coincident with a handshake: the handshake completes (the core consumed the word), then the flush applies.
- FIFO never overflows: the credit rule guarantees `count`+`inflight` ≤ DEPTH. A pop with `count`=0 is impossible because `instr_valid`=0.
- Unused FIFO entries hold stale data. `instr`/`instr_pc` are don't-care while `instr_valid`=0, except after reset.

## Timing
- Reset values: `fetch_pc`=0, `count`=0, `inflight`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_req`=0 while `reset`=1.
- First cycle after reset release: `mem_req`=1, `mem_addr`=0.
- Fetch latency: issue in cycle N → data sampled at the end of N+1 → `instr_valid`=1 in N+2.
- Redirect latency: `redirect` in cycle N → `mem_req` at `redirect_addr` in N+1 → `instr_valid` in N+3, with `instr_pc`=`redirect_addr`.
- Throughput: with `instr_ready` held at 1, one instruction per cycle sustained after the initial fill.
- Backpressure: with `instr_ready`=0 the FIFO fills to DEPTH and `mem_req` stays 0. After ready returns, the next issue occurs the cycle after the first pop.
- Reset mid-operation: all state clears asynchronously; in-flight data is ignored; behaviour restarts at address 0.

## Test plan
- Reset release, memory returns word = {5'b0, addr}, `instr_ready`=1 → `instr_valid` from cycle 2; `instr_pc` = 0,1,2,… one per cycle; `instr` matches the memory model.
- `instr_ready`=0 for 10 cycles → exactly DEPTH (4) words buffered, pcs 0–3; `mem_req` low after the 4th issue. Release ready → pcs 0,1,2,3,4,… in order, none lost or duplicated.
- `redirect`=1, `redirect_addr`=0x0100 while a read is in flight and the FIFO holds 2 entries → the in-flight word is dropped; next accepted `instr_pc`=0x0100, exactly 3 cycles after redirect.
- Redirect to 0x3FFE with ready=1 → accepted pcs 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Redirect and handshake in the same cycle → the handshaked word counts as accepted once; the next accepted pc equals `redirect_addr`.
- Assert `reset` mid-stream with a full FIFO → outputs go to reset values immediately; after release the stream restarts at pc 0 with no stale words.
